f1_start_seq: RTL and testbench

F1_START_SEQ -- requirements
Module: f1_start_seq

---
 rtl/f1_start_seq.sv | 88 ++++++++
 tb/tb_f1_start_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/f1_start_seq.sv
// f1_start_seq: start-light sequencer with a random LFSR hold time and reaction timer.
module f1_start_seq #(
  parameter int NUM_LIGHTS = 8,
  parameter int LFSR_WIDTH = 7,
  parameter int DIV_WIDTH  = 5,
  parameter int RT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic [DIV_WIDTH-1:0]  n,
  input  logic                  react,
  output logic [NUM_LIGHTS-1:0] data_out,
  output logic                  busy,
  output logic                  react_valid,
  output logic [RT_WIDTH-1:0]   react_time,
  output logic                  jump_start
);
  localparam logic [1:0] IDLE = 2'd0, SEQ = 2'd1, HOLD = 2'd2, RUN = 2'd3;
  // bit e-1 set for each x^e term of the tap polynomial (constant term implied)
  localparam logic [7:0] TAP8 = LFSR_WIDTH == 4 ? 8'b0000_1100 :
                                LFSR_WIDTH == 5 ? 8'b0001_0100 :
                                LFSR_WIDTH == 6 ? 8'b0011_0000 :
                                LFSR_WIDTH == 7 ? 8'b0100_0100 : 8'b1011_1000;
  localparam logic [LFSR_WIDTH-1:0] TAPS = TAP8[LFSR_WIDTH-1:0];
  logic [1:0]            state;
  logic [DIV_WIDTH-1:0]  div;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [LFSR_WIDTH-1:0] hold_cnt;
  logic [RT_WIDTH-1:0]   rt_cnt;
  logic                  trig_q;
  logic                  trig_armed;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      data_out    <= '0;
      react_valid <= 1'b0;
      jump_start  <= 1'b0;
      react_time  <= '0;
      div         <= '0;
      lfsr        <= LFSR_WIDTH'(1);
      hold_cnt    <= '0;
      rt_cnt      <= '0;
      trig_q      <= 1'b0;
      trig_armed  <= 1'b0;
    end else begin
      lfsr        <= {lfsr[LFSR_WIDTH-2:0], ^(lfsr & TAPS)};
      trig_q      <= trigger;
      // a trigger held high across reset must be seen low before it can start a run
      trig_armed  <= trig_armed | ~trigger;
      react_valid <= 1'b0;
      jump_start  <= 1'b0;
      if ((state == SEQ || state == HOLD) && react) begin
        state      <= IDLE;
        data_out   <= '0;
        jump_start <= 1'b1;
      end else begin
        case (state)
          IDLE: if (trigger && !trig_q && trig_armed) begin
            state    <= SEQ;
            div      <= n;
            data_out <= '0;
          end
          SEQ: if (div == '0) begin
            div      <= n;
            data_out <= {data_out[NUM_LIGHTS-2:0], 1'b1};
            if (&data_out[NUM_LIGHTS-2:0]) begin
              state    <= HOLD;
              hold_cnt <= lfsr;
            end
          end else div <= div - DIV_WIDTH'(1);
          HOLD: if (hold_cnt == LFSR_WIDTH'(1)) begin
            state    <= RUN;
            data_out <= '0;
            rt_cnt   <= '0;
          end else hold_cnt <= hold_cnt - LFSR_WIDTH'(1);
          RUN: if (react || &rt_cnt) begin
            state       <= IDLE;
            react_time  <= rt_cnt;
            react_valid <= 1'b1;
          end else rt_cnt <= rt_cnt + RT_WIDTH'(1);
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_f1_start_seq.sv
// tb_f1_start_seq: randomized self-checking bench for f1_start_seq against a sequence-level model.
module tb_f1_start_seq;
  localparam int NL = 8, LW = 7, DW = 5, RW = 4;
  localparam int RT_MAX = (1 << RW) - 1;
  logic clk = 1'b0, rst = 1'b0, trigger = 1'b0, react = 1'b0;
  logic [DW-1:0] n = '0;
  logic [NL-1:0] data_out;
  logic busy, react_valid, jump_start;
  logic [RW-1:0] react_time;
  int checks = 0, failures = 0;
  int exp_rt = 0;
  int m_lfsr;

  f1_start_seq #(.NUM_LIGHTS(NL), .LFSR_WIDTH(LW), .DIV_WIDTH(DW), .RT_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .n(n), .react(react),
    .data_out(data_out), .busy(busy), .react_valid(react_valid),
    .react_time(react_time), .jump_start(jump_start)
  );

  always #5 clk = ~clk;

  // x^7 + x^3 + 1: feedback is the XOR of the stages for the x^7 and x^3 terms
  function automatic int lfsr_next(input int s);
    int fb;
    fb = ((s >> (7 - 1)) & 1) ^ ((s >> (3 - 1)) & 1);
    return ((s << 1) | fb) & 'h7f;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) m_lfsr <= 1;
    else m_lfsr <= lfsr_next(m_lfsr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: react in RUN at counter value arg (arg > RT_MAX -> saturate)
  // mode 1: react at SEQ cycle arg (0-based from SEQ entry); mode 2: react at HOLD cycle arg (clamped to last)
  task automatic run_seq(input int nv, input int mode, input int arg, input bit retrig, input string tag);
    int k;
    bit jumped;
    logic [NL-1:0] exp_d;
    k = 0;
    jumped = 0;
    n = DW'(nv);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    checks++;
    if (busy !== 1'b1 || data_out !== '0) begin
      failures++;
      $display("FAIL %s seq_entry: busy=%b data_out=%h want busy=1 data_out=0", tag, busy, data_out);
    end
    for (int l = 1; l <= NL; l++)
      for (int c = 0; c <= nv; c++)
        if (!jumped) begin
          if (l == NL && c == nv) k = m_lfsr;
          react = (mode == 1 && arg == (l - 1) * (nv + 1) + c);
          step();
          jumped = react;
          react = 1'b0;
          exp_d = (c == nv) ? NL'((1 << l) - 1) : NL'((1 << (l - 1)) - 1);
          if (!jumped) begin
            checks++;
            if (data_out !== exp_d || busy !== 1'b1) begin
              failures++;
              $display("FAIL %s lights l=%0d c=%0d: data_out=%h busy=%b want %h busy=1", tag, l, c, data_out, busy, exp_d);
            end
          end
        end
    for (int h = 0; h < k; h++)
      if (!jumped) begin
        react = (mode == 2 && h == (arg < k ? arg : k - 1));
        trigger = retrig && h == 0;
        step();
        trigger = 1'b0;
        jumped = react;
        react = 1'b0;
        exp_d = (h == k - 1) ? '0 : '1;
        if (!jumped) begin
          checks++;
          if (data_out !== exp_d || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s hold h=%0d k=%0d: data_out=%h busy=%b want %h busy=1", tag, h, k, data_out, busy, exp_d);
          end
        end
      end
    if (jumped) begin
      checks++;
      if (jump_start !== 1'b1 || data_out !== '0 || busy !== 1'b0 || react_valid !== 1'b0 || react_time !== RW'(exp_rt)) begin
        failures++;
        $display("FAIL %s jump: js=%b data_out=%h busy=%b rv=%b rt=%0d want js=1 data_out=0 busy=0 rv=0 rt=%0d",
                 tag, jump_start, data_out, busy, react_valid, react_time, exp_rt);
      end
      step();
      checks++;
      if (jump_start !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL %s jump_after: js=%b busy=%b want js=0 busy=0", tag, jump_start, busy);
      end
    end else begin
      for (int c = 0; c <= RT_MAX; c++) begin
        react = (mode == 0 && c == arg);
        step();
        if (react || c == RT_MAX) begin
          react = 1'b0;
          exp_rt = c;
          checks++;
          if (react_valid !== 1'b1 || react_time !== RW'(exp_rt) || busy !== 1'b0 || jump_start !== 1'b0) begin
            failures++;
            $display("FAIL %s react: rv=%b rt=%0d busy=%b js=%b want rv=1 rt=%0d busy=0 js=0",
                     tag, react_valid, react_time, busy, jump_start, exp_rt);
          end
          step();
          checks++;
          if (react_valid !== 1'b0 || react_time !== RW'(exp_rt) || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s react_after: rv=%b rt=%0d busy=%b want rv=0 rt=%0d busy=0", tag, react_valid, react_time, busy, exp_rt);
          end
          break;
        end
        react = 1'b0;
        checks++;
        if (react_valid !== 1'b0 || busy !== 1'b1 || data_out !== '0) begin
          failures++;
          $display("FAIL %s run c=%0d: rv=%b busy=%b data_out=%h want rv=0 busy=1 data_out=0", tag, c, react_valid, busy, data_out);
        end
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (busy !== 1'b0 || data_out !== '0 || react_valid !== 1'b0 || jump_start !== 1'b0 || react_time !== '0) begin
      failures++;
      $display("FAIL reset: busy=%b data_out=%h rv=%b js=%b rt=%0d want all 0", busy, data_out, react_valid, jump_start, react_time);
    end
    step();
    step();
    #3 rst = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || data_out !== '0) begin
      failures++;
      $display("FAIL reset_release: busy=%b data_out=%h want busy=0 data_out=0", busy, data_out);
    end
  endtask

  task automatic test_idle_react();
    react = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || react_valid !== 1'b0 || jump_start !== 1'b0 || react_time !== RW'(exp_rt)) begin
        failures++;
        $display("FAIL idle_react: busy=%b rv=%b js=%b rt=%0d want 0 0 0 %0d", busy, react_valid, jump_start, react_time, exp_rt);
      end
    end
    react = 1'b0;
    step();
  endtask

  task automatic test_pattern();
    run_seq(2, 0, 3, 1'b0, "n2_react3");
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++)
      run_seq(int'($urandom_range(0, 3)), 0, int'($urandom_range(0, RT_MAX)), 1'b0, "random");
  endtask

  task automatic test_jump_start();
    int nv;
    run_seq(1, 1, 3 * 2, 1'b0, "jump_3lights");
    nv = int'($urandom_range(0, 3));
    run_seq(nv, 1, NL * (nv + 1) - 1, 1'b0, "jump_final_tick");
    nv = int'($urandom_range(0, 3));
    run_seq(nv, 1, int'($urandom_range(0, NL * (nv + 1) - 1)), 1'b0, "jump_seq_rand");
    run_seq(0, 2, int'($urandom_range(0, 20)), 1'b0, "jump_hold_rand");
    run_seq(1, 2, 1000, 1'b0, "jump_hold_last");
  endtask

  task automatic test_saturation();
    run_seq(0, 0, 1000, 1'b0, "saturate");
  endtask

  task automatic test_retrigger();
    run_seq(0, 0, int'($urandom_range(0, RT_MAX)), 1'b1, "retrig_n0");
  endtask

  task automatic test_reset_mid();
    n = '0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (NL) step();
    checks++;
    if (data_out !== '1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_hold_entry: data_out=%h busy=%b want ff busy=1", data_out, busy);
    end
    #3 rst = 1'b0;
    trigger = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || data_out !== '0 || react_valid !== 1'b0 || jump_start !== 1'b0 || react_time !== '0) begin
      failures++;
      $display("FAIL mid_reset_async: busy=%b data_out=%h rv=%b js=%b rt=%0d want all 0", busy, data_out, react_valid, jump_start, react_time);
    end
    step();
    checks++;
    if (busy !== 1'b0 || data_out !== '0 || react_valid !== 1'b0 || jump_start !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_held: busy=%b data_out=%h rv=%b js=%b want all 0", busy, data_out, react_valid, jump_start);
    end
    exp_rt = 0;
    #3 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL trigger_held_after_reset: busy=%b want 0", busy);
      end
    end
    trigger = 1'b0;
    step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    checks++;
    if (busy !== 1'b1 || data_out !== '0) begin
      failures++;
      $display("FAIL trigger_rearm: busy=%b data_out=%h want busy=1 data_out=0", busy, data_out);
    end
    react = 1'b1;
    step();
    react = 1'b0;
    checks++;
    if (jump_start !== 1'b1 || busy !== 1'b0 || react_time !== '0) begin
      failures++;
      $display("FAIL rearm_jump: js=%b busy=%b rt=%0d want js=1 busy=0 rt=0", jump_start, busy, react_time);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_idle_react();
    test_pattern();
    test_random();
    test_jump_start();
    test_saturation();
    test_retrigger();
    test_reset_mid();
    run_seq(3, 0, int'($urandom_range(0, RT_MAX)), 1'b0, "post_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
